// File: rtl/dc_fifo_pkg.sv
// Shared helpers for the dual-clock first-word-fall-through FIFO.
// Gray conversion plus pointer and occupancy width helpers.
package dc_fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic int ptr_w(input int aw);
        return aw + 1;
    endfunction

    // Occupancy spans 0..2**aw inclusive, so it needs one extra bit.
    function automatic int level_w(input int aw);
        return aw + 1;
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_gray_ptr.sv
// Carries a binary pointer across clock domains as registered Gray code.
// The source flop holds the Gray form of the next pointer, so it tracks the binary register.
module cdc_gray_ptr
    import dc_fifo_pkg::*;
#(
    parameter int W           = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic         i_src_clk,
    input  logic         i_src_rst,
    input  logic [W-1:0] i_src_bin_nxt,
    input  logic         i_dst_clk,
    input  logic         i_dst_rst,
    output logic [W-1:0] o_dst_bin
);

    logic [W-1:0] r_src_gray;
    logic [W-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge i_src_clk) begin
        if (i_src_rst) begin
            r_src_gray <= '0;
        end else begin
            r_src_gray <= W'(bin2gray(32'(i_src_bin_nxt)));
        end
    end

    always_ff @(posedge i_dst_clk) begin
        if (i_dst_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= r_src_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_dst_bin = W'(gray2bin(32'(r_sync[SYNC_STAGES-1])));

endmodule

// File: rtl/dc_fifo_ram.sv
// Simple dual-clock RAM: write port on one clock, registered read port on the other.
module dc_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          i_wclk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_rclk,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_wclk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_rclk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dc_fifo_fwft.sv
// Dual-clock FIFO with valid/ready on both sides and first-word-fall-through output.
// A slot is released to the writer only once its word has been popped by the consumer.
module dc_fifo_fwft
    import dc_fifo_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 2**AW - 2,
    parameter int AEMPTY_TH   = 2
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [AW:0]   w_level,
    output logic          w_afull,
    input  logic          r_clk,
    input  logic          r_rst,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   r_level,
    output logic          r_aempty
);

    localparam int PW = ptr_w(AW);
    localparam int LW = level_w(AW);
    localparam logic [LW-1:0] DEPTH  = LW'(2**AW);
    localparam logic [LW-1:0] AF_TH  = LW'(AFULL_TH);
    localparam logic [LW-1:0] AE_TH  = LW'(AEMPTY_TH);

    // Write domain
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_cptr_sync;
    logic [LW-1:0] w_wlevel_nxt;
    logic          w_push;
    logic          w_we;

    assign w_push       = s_valid && s_ready;
    assign w_we         = w_push && !w_rst;
    assign w_wptr_nxt   = r_wptr + PW'(w_push);
    assign w_wlevel_nxt = w_wptr_nxt - w_cptr_sync;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_wptr  <= '0;
            s_ready <= 1'b0;
            w_level <= '0;
            w_afull <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            s_ready <= (w_wlevel_nxt != DEPTH);
            w_level <= w_wlevel_nxt;
            w_afull <= (w_wlevel_nxt >= AF_TH);
        end
    end

    // Read domain: fptr addresses the RAM, cptr counts consumed words
    logic [PW-1:0] r_fptr;
    logic [PW-1:0] r_cptr;
    logic [PW-1:0] w_cptr_nxt;
    logic [PW-1:0] w_wptr_sync;
    logic [LW-1:0] w_rlevel_nxt;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] r_skid_data;
    logic          r_skid_valid;
    logic          r_inflight;
    logic          w_pop;
    logic          w_fetch;
    logic          w_head_free;
    logic [1:0]    w_occ;

    assign w_pop       = m_valid && m_ready;
    assign w_head_free = !m_valid || m_ready;
    assign w_occ       = {1'b0, m_valid} + {1'b0, r_skid_valid}
                       + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_fetch     = !r_rst && (r_fptr != w_wptr_sync) && (w_occ < 2'd2);
    assign w_cptr_nxt  = r_cptr + PW'(w_pop);
    assign w_rlevel_nxt = w_wptr_sync - w_cptr_nxt;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_fptr     <= '0;
            r_cptr     <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
            r_aempty   <= 1'b1;
        end else begin
            r_fptr     <= r_fptr + PW'(w_fetch);
            r_cptr     <= w_cptr_nxt;
            r_inflight <= w_fetch;
            r_level    <= w_rlevel_nxt;
            r_aempty   <= (w_rlevel_nxt <= AE_TH);
        end
    end

    // Head plus skid slot: a word read while the head stalls parks in the skid
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            m_valid      <= 1'b0;
            m_data       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_head_free) begin
            if (r_skid_valid) begin
                m_valid      <= 1'b1;
                m_data       <= r_skid_data;
                r_skid_valid <= r_inflight;
                r_skid_data  <= w_rdata;
            end else begin
                m_valid <= r_inflight;
                if (r_inflight) begin
                    m_data <= w_rdata;
                end
            end
        end else if (r_inflight) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_rdata;
        end
    end

    dc_fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .i_wclk  (w_clk),
        .i_we    (w_we),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (s_data),
        .i_rclk  (r_clk),
        .i_re    (w_fetch),
        .i_raddr (r_fptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    cdc_gray_ptr #(
        .W           (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wptr_cdc (
        .i_src_clk     (w_clk),
        .i_src_rst     (w_rst),
        .i_src_bin_nxt (w_wptr_nxt),
        .i_dst_clk     (r_clk),
        .i_dst_rst     (r_rst),
        .o_dst_bin     (w_wptr_sync)
    );

    cdc_gray_ptr #(
        .W           (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cptr_cdc (
        .i_src_clk     (r_clk),
        .i_src_rst     (r_rst),
        .i_src_bin_nxt (w_cptr_nxt),
        .i_dst_clk     (w_clk),
        .i_dst_rst     (w_rst),
        .o_dst_bin     (w_cptr_sync)
    );

endmodule

// File: doc/dc_fifo_fwft.md
Name: dc_fifo_fwft

Overview:
Parametrised dual-clock FIFO, successor to the team's basic dual-clock FIFO. Adds valid/ready handshakes on both sides, first-word-fall-through output with full-rate (1 word/cycle) streaming, true 2**AW capacity using AW+1-bit pointers, and registered almost-full/almost-empty flags. Sits on any stream crossing between two asynchronous clock domains.

Parameters:
DW, 8, data width in bits
AW, 4, address width; capacity DEPTH = 2**AW words
SYNC_STAGES, 2, synchroniser flops per pointer crossing (>=2)
AFULL_TH, 2**AW-2, w_afull asserts when w_level >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, r_aempty asserts when r_level <= AEMPTY_TH (0..DEPTH-1)

Ports:
w_clk  in  1  write-domain clock
w_rst  in  1  write-domain reset, synchronous, active-high
s_data  in  DW  write data
s_valid  in  1  write request
s_ready  out  1  FIFO can accept; word is written when s_valid && s_ready
w_level  out  AW+1  occupancy seen from write side, 0..DEPTH
w_afull  out  1  almost-full, registered
r_clk  in  1  read-domain clock
r_rst  in  1  reset r_rst, synchronous, active-high; clock r_clk
m_data  out  DW  head word, valid while m_valid
m_valid  out  1  head word present
m_ready  in  1  consumer accepts; word popped when m_valid && m_ready
r_level  out  AW+1  occupancy seen from read side, 0..DEPTH
r_aempty  out  1  almost-empty, registered

Behaviour:
- Pointers AW+1 bits, binary internally, crossed as Gray code through SYNC_STAGES flops; only Gray registers cross domains.
- wptr increments on write handshake. Read side keeps fptr (fetch, addresses RAM) and cptr (consumed, increments on m_valid && m_ready). cptr is the pointer sent to write domain, so a word frees its slot only after consumption; capacity exactly DEPTH.
- w_level = wptr - cptr_sync (mod 2**(AW+1)); r_level = wptr_sync - cptr. Registered outputs; conservative (w_level may over-report, r_level may under-report, never the reverse).
- s_ready = registered !(next w_level == DEPTH); never accepts into a full FIFO; write with s_ready low is ignored, no state change.
- RAM: simple dual-port, synchronous 1-cycle read on r_clk.
- Output stage: 2-entry buffer (head + skid). Fetch issued when fptr != wptr_sync and buffered + in-flight words < 2. Guarantees m_valid stays high and one pop per r_clk under continuous m_ready when data available.
- m_data/m_valid are registers; m_data holds stable while m_valid && !m_ready.
- Latency: word written at w_clk edge appears (m_valid=1) within SYNC_STAGES+3 r_clk edges after that edge plus at most one r_clk of phase uncertainty. Pop to s_ready/w_level update: within SYNC_STAGES+2 w_clk edges.
- Flags: w_afull <= (w_level_next >= AFULL_TH); r_aempty <= (r_level_next <= AEMPTY_TH).
- Wrap-around: pointers wrap modulo 2**(AW+1); full = MSBs differ, lower AW bits equal; empty = equal.
- Simultaneous push/pop at full: pop frees slot only after sync; s_ready stays 0 until freed count arrives.
- Reset values: s_ready 0 during w_rst, rises first w_clk after release; w_level 0, w_afull 0; m_valid 0, m_data '0, r_level 0, r_aempty 1; all pointers and synchronisers 0.
- Resets: both domains must be reset together, each held >= SYNC_STAGES+2 cycles of the slower clock. Single-domain reset mid-operation unsupported; bench checks only that the reset domain's outputs reach reset values.

Decomposition:
- Package dc_fifo_pkg: Gray conversion functions bin2gray/gray2bin, pointer width constant expression (AW+1), level typedef helper.
- Sub-module cdc_gray_ptr: binary pointer in source domain -> registered Gray -> SYNC_STAGES flops -> binary in destination domain; instantiated twice (wptr to r_clk, cptr to w_clk).
- RAM: existing simple dual-clock RAM.

Test Plan:
- Reset, AW=4: after both resets -> s_ready=1, m_valid=0, r_aempty=1, w_level=0; no spurious m_valid for 50 r_clk.
- Fill: 16 writes, m_ready=0 -> 17th attempt sees s_ready=0, w_level=16, w_afull=1 from level 14; after sync r_level=16; drain yields data 0..15 in order.
- Streaming, w_clk 100 MHz, r_clk 70 MHz, m_ready=1, 1000 random words -> zero loss/duplication/reorder; m_valid gaps only when r_level=0.
- FWFT latency: single write to empty FIFO -> m_valid within SYNC_STAGES+3 r_clk edges, m_data equals word, held stable with m_ready=0 for 20 cycles.
- Backpressure: random m_ready 30% duty, random s_valid, 3 pointer wraps -> scoreboard match; w_level never exceeds 16; r_level never exceeds true occupancy.
- Clock ratios 1:4 and 4:1 with full/empty bouncing -> no overflow, no underflow, r_aempty asserts at r_level<=2.
